// File: rtl/scan_chain_capture_ip2.sv
// Reads the IP2 ASIC scan chain back: one parallel-load period, then shift-out, packed LSB-first into word memory.
// Latency: capture takes 1 + 2*hp*SCAN_BITS cycles from start to done; readback port is registered, 1 cycle.
// Backpressure: none; start is ignored while busy, abort cancels in any state.
module scan_chain_capture_ip2 #(
    parameter int SCAN_BITS = 768,
    parameter int WORD_W    = 32,
    parameter int HP_W      = 6,
    parameter int ADDR_W    = 5
) (
    input  logic              fw_pl_clk1,
    input  logic              fw_reset,
    input  logic [HP_W-1:0]   cfg_half_period,
    input  logic              start,
    input  logic              abort,
    input  logic              scan_out_i,
    output logic              scan_clk_o,
    output logic              scan_load_o,
    output logic              busy,
    output logic              done,
    output logic              data_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int NWORDS = SCAN_BITS / WORD_W;
    localparam int PC_W   = $clog2(SCAN_BITS);
    localparam int BC_W   = $clog2(WORD_W);

    localparam logic [PC_W-1:0]   LAST_PERIOD = PC_W'(SCAN_BITS - 1);
    localparam logic [BC_W-1:0]   LAST_BIT    = BC_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD   = ADDR_W'(NWORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    logic [HP_W-1:0]   hp_q;
    logic [HP_W-1:0]   hp_cnt;
    logic [PC_W-1:0]   period_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] mem [NWORDS];

    logic              active;
    logic              start_ok;
    logic              phase_end;
    logic              sample;
    logic              last_bit;
    logic              word_full;
    logic [WORD_W-1:0] word_next;

    assign active    = (state == ST_LOAD) || (state == ST_SHIFT);
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign phase_end = (hp_cnt == (hp_q - HP_W'(1)));
    // Sample in the last high cycle, i.e. the cycle whose edge drives scan_clk_o low.
    assign sample    = active && scan_clk_o && phase_end;
    assign last_bit  = (period_cnt == LAST_PERIOD);
    assign word_full = (bit_cnt == LAST_BIT);
    assign word_next = {scan_out_i, shreg[WORD_W-1:1]};

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_reset) begin
            state       <= ST_IDLE;
            hp_q        <= '0;
            hp_cnt      <= '0;
            period_cnt  <= '0;
            bit_cnt     <= '0;
            word_idx    <= '0;
            shreg       <= '0;
            scan_clk_o  <= 1'b0;
            scan_load_o <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state       <= ST_IDLE;
                scan_clk_o  <= 1'b0;
                scan_load_o <= 1'b1;
                busy        <= 1'b0;
                data_valid  <= 1'b0;
            end else if (start_ok) begin
                state       <= ST_LOAD;
                hp_q        <= (cfg_half_period == '0) ? HP_W'(1) : cfg_half_period;
                hp_cnt      <= '0;
                period_cnt  <= '0;
                bit_cnt     <= '0;
                word_idx    <= '0;
                scan_clk_o  <= 1'b0;
                scan_load_o <= 1'b1;
                busy        <= 1'b1;
                data_valid  <= 1'b0;
            end else if (active) begin
                if (phase_end) begin
                    hp_cnt     <= '0;
                    scan_clk_o <= ~scan_clk_o;
                end else begin
                    hp_cnt <= hp_cnt + HP_W'(1);
                end

                if (sample) begin
                    shreg   <= word_next;
                    bit_cnt <= word_full ? '0 : bit_cnt + BC_W'(1);
                    if (word_full) begin
                        word_idx <= word_idx + ADDR_W'(1);
                    end
                    // Period 0 is the parallel-load period; shifting starts at its sample edge.
                    if (state == ST_LOAD) begin
                        state       <= ST_SHIFT;
                        scan_load_o <= 1'b0;
                    end
                    if (last_bit) begin
                        state       <= ST_DONE;
                        scan_load_o <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        data_valid  <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + PC_W'(1);
                    end
                end
            end
        end
    end

    // Words land in memory as soon as their top bit is sampled; abort leaves them in place.
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (sample && word_full && !abort) begin
            mem[word_idx] <= word_next;
        end
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_reset) begin
            rd_data <= '0;
        end else if (rd_addr <= LAST_WORD) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_scan_chain_capture_ip2.sv
// Randomized scoreboard bench for scan_chain_capture_ip2 with a behavioural ASIC scan-chain model.
module tb_scan_chain_capture_ip2;

    localparam int SCAN_BITS = 768;
    localparam int WORD_W    = 32;
    localparam int NWORDS    = SCAN_BITS / WORD_W;

    logic        fw_pl_clk1 = 1'b0;
    logic        fw_reset   = 1'b1;
    logic [5:0]  cfg_half_period = 6'd1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        scan_out_i = 1'b0;
    logic        scan_clk_o;
    logic        scan_load_o;
    logic        busy;
    logic        done;
    logic        data_valid;
    logic [4:0]  rd_addr = 5'd0;
    logic [31:0] rd_data;

    scan_chain_capture_ip2 dut (
        .fw_pl_clk1      (fw_pl_clk1),
        .fw_reset        (fw_reset),
        .cfg_half_period (cfg_half_period),
        .start           (start),
        .abort           (abort),
        .scan_out_i      (scan_out_i),
        .scan_clk_o      (scan_clk_o),
        .scan_load_o     (scan_load_o),
        .busy            (busy),
        .done            (done),
        .data_valid      (data_valid),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
    );

    always #5 fw_pl_clk1 = ~fw_pl_clk1;

    int cyc = 0;
    always @(posedge fw_pl_clk1) cyc <= cyc + 1;

    typedef struct { int done_cyc; int hp; } cap_t;
    typedef struct { int addr; logic [31:0] data; } rd_t;
    cap_t done_q[$];
    rd_t  rd_q[$];

    bit          pat [SCAN_BITS];
    logic [31:0] ref_mem [NWORDS];
    logic        rd_en   = 1'b0;
    logic        rd_en_d = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge fw_pl_clk1) rd_en_d <= rd_en;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ASIC model: after the load, bit k sits on the serial line during scan period k.
    int   fe_cnt = 0;
    logic m_prev_clk = 1'b0;
    logic m_prev_busy = 1'b0;
    always @(negedge fw_pl_clk1) begin
        if (busy && !m_prev_busy) fe_cnt = 0;
        else if (m_prev_clk && !scan_clk_o) fe_cnt = fe_cnt + 1;
        m_prev_clk  = scan_clk_o;
        m_prev_busy = busy;
        scan_out_i  = (fe_cnt < SCAN_BITS) ? pat[fe_cnt] : 1'b0;
    end

    // Monitor: waveform statistics per capture, done pulses and read responses.
    int   rise_cnt = 0, bad_runs = 0, run_len = 0, load_hi = 0, load_lo = 0;
    logic w_prev_clk = 1'b0;
    logic w_prev_busy = 1'b0;
    always @(negedge fw_pl_clk1) begin
        int   hp;
        cap_t e;
        rd_t  r;
        hp = (done_q.size() > 0) ? done_q[0].hp : 0;
        if (busy && !w_prev_busy) begin
            rise_cnt = 0; bad_runs = 0; run_len = 1; load_hi = 0; load_lo = 0;
        end else if (busy || done) begin
            if (scan_clk_o != w_prev_clk) begin
                if (run_len != hp) bad_runs++;
                run_len = 1;
                if (scan_clk_o) rise_cnt++;
            end else begin
                run_len++;
            end
        end
        if (busy) begin
            if (scan_load_o) load_hi++;
            else             load_lo++;
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("done_busy", busy, 0);
                chk("done_data_valid", data_valid, 1);
                chk("done_scan_load", scan_load_o, 1);
                chk("done_scan_clk", scan_clk_o, 0);
                chk("rising_edges", rise_cnt, SCAN_BITS);
                chk("bad_half_periods", bad_runs, 0);
                chk("load_high_cycles", load_hi, 2 * e.hp);
                chk("load_low_cycles", load_lo, 2 * e.hp * (SCAN_BITS - 1));
            end
        end
        if (rd_en_d) begin
            if (rd_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_unexpected: read response with empty scoreboard at cycle %0d", cyc);
            end else begin
                r = rd_q.pop_front();
                chk($sformatf("rd_word[%0d]", r.addr), rd_data, r.data);
            end
        end
        w_prev_clk  = scan_clk_o;
        w_prev_busy = busy;
    end

    function automatic logic [31:0] pack_word(input int w);
        logic [31:0] v = '0;
        for (int j = 0; j < WORD_W; j++) v[j] = pat[w * WORD_W + j];
        return v;
    endfunction

    task automatic tick();
        @(posedge fw_pl_clk1);
        #1;
    endtask

    task automatic do_start(input int cfg);
        int eff;
        eff = (cfg == 0) ? 1 : cfg;
        cfg_half_period = 6'(cfg);
        start = 1'b1;
        done_q.push_back('{cyc + 1 + 2 * eff * SCAN_BITS, eff});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
            done_q.delete();
        end
    endtask

    task automatic rd(input int a);
        rd_addr = 5'(a);
        rd_en   = 1'b1;
        rd_q.push_back('{a, (a < NWORDS) ? ref_mem[a] : 32'h0});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < NWORDS; a++) rd(a);
        rd(24);
        rd(31);
        tick();
    endtask

    task automatic rand_pattern();
        for (int k = 0; k < SCAN_BITS; k++) pat[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic commit_all();
        for (int w = 0; w < NWORDS; w++) ref_mem[w] = pack_word(w);
    endtask

    task automatic full_capture(input int cfg);
        int eff;
        eff = (cfg == 0) ? 1 : cfg;
        do_start(cfg);
        wait_done(2 * eff * SCAN_BITS + 50);
        commit_all();
        chk("post_done_data_valid", data_valid, 1);
        read_all();
    endtask

    initial begin
        int s;
        for (int w = 0; w < NWORDS; w++) ref_mem[w] = '0;
        for (int k = 0; k < SCAN_BITS; k++) pat[k] = 1'b0;

        repeat (3) tick();
        chk("rst_scan_clk", scan_clk_o, 0);
        chk("rst_scan_load", scan_load_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        fw_reset = 1'b0;
        tick();
        read_all();

        // Fixed pattern, hp = 1
        for (int k = 0; k < SCAN_BITS; k++) pat[k] = k[0] ^ k[3];
        full_capture(1);

        // cfg 0 behaves as 1; cfg 5 stretches each half period to 5 cycles
        rand_pattern();
        full_capture(0);
        rand_pattern();
        full_capture(5);

        // Second start and cfg change mid-capture are both ignored
        rand_pattern();
        do_start(1);
        repeat (99) tick();
        start = 1'b1;
        cfg_half_period = 6'd7;
        tick();
        start = 1'b0;
        wait_done(2 * SCAN_BITS + 50);
        commit_all();
        read_all();

        // Abort 700 cycles into an hp=1 capture; fully written words survive
        rand_pattern();
        s = cyc;
        do_start(1);
        repeat (699) tick();
        abort = 1'b1;
        void'(done_q.pop_back());
        for (int w = 0; w < NWORDS; w++)
            if (2 * (WORD_W * w + WORD_W) < (cyc - s)) ref_mem[w] = pack_word(w);
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_data_valid", data_valid, 0);
        chk("abort_scan_load", scan_load_o, 1);
        chk("abort_scan_clk", scan_clk_o, 0);
        read_all();

        // start and abort together in IDLE: nothing happens
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("idle_start_abort_busy", busy, 0);
        repeat (10) tick();
        chk("idle_start_abort_busy_later", busy, 0);

        rand_pattern();
        full_capture(2);

        // Reset mid-capture clears everything including memory
        rand_pattern();
        do_start(1);
        repeat (299) tick();
        fw_reset = 1'b1;
        void'(done_q.pop_back());
        tick();
        fw_reset = 1'b0;
        for (int w = 0; w < NWORDS; w++) ref_mem[w] = '0;
        chk("mid_rst_scan_clk", scan_clk_o, 0);
        chk("mid_rst_scan_load", scan_load_o, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data_valid", data_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        read_all();

        // Random captures with random half periods and random reads
        for (int t = 0; t < 3; t++) begin
            int cfg;
            cfg = $urandom_range(0, 3);
            rand_pattern();
            do_start(cfg);
            wait_done(2 * ((cfg == 0) ? 1 : cfg) * SCAN_BITS + 50);
            commit_all();
            for (int i = 0; i < 8; i++) rd($urandom_range(0, 31));
            tick();
        end

        repeat (5) tick();
        if (done_q.size() != 0 || rd_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: %0d done and %0d reads outstanding", done_q.size(), rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
